// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead add/sub: operands are registered, then GPS 4-bit groups per stage, carry registered between stages.
// Latency LAT=NG/GPS cycles after acceptance; one global advance, so a stalled output freezes every stage and drops in_ready.
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NG  = WIDTH / 4;
  localparam int LAT = NG / GPS;

  // Level 0 holds the raw operands; level k+1 holds the result of stage k.
  logic [LAT:0]       v_q, v_d;
  logic [LAT:0]       c_q, c_d;
  logic [WIDTH-1:0]   s_q [LAT+1];
  logic [WIDTH-1:0]   s_d [LAT+1];
  logic [WIDTH-1:0]   a_q [LAT];
  logic [WIDTH-1:0]   a_d [LAT];
  logic [WIDTH-1:0]   b_q [LAT];
  logic [WIDTH-1:0]   b_d [LAT];
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               adv;
  logic               carry;
  logic               c_msb;
  logic [5:0]         grp;
  int                 base;

  // Returns {carry out, carry into bit 3, sum[3:0]} of one lookahead group.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
    logic [3:0] g, p, c;
    g = x & y;
    p = x ^ y;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[3], c[2], p ^ {c[2:0], cin}};
  endfunction

  always_comb begin
    adv   = !v_q[LAT] | out_ready;
    v_d   = {v_q[LAT-1:0], in_valid};
    c_d   = '0;
    carry = 1'b0;
    c_msb = 1'b0;
    grp   = '0;
    base  = 0;
    for (int k = 0; k <= LAT; k++) s_d[k] = '0;
    for (int k = 0; k < LAT; k++) begin
      a_d[k] = '0;
      b_d[k] = '0;
    end
    // Subtraction becomes A + ~B + 1 at the input; sub needs no further storage.
    a_d[0] = a;
    b_d[0] = b ^ {WIDTH{sub}};
    c_d[0] = sub | ci;
    for (int k = 0; k < LAT; k++) begin
      s_d[k+1] = s_q[k];
      carry    = c_q[k];
      if (k < LAT - 1) begin
        a_d[k+1] = a_q[k];
        b_d[k+1] = b_q[k];
      end
      for (int j = 0; j < GPS; j++) begin
        base = (k * GPS + j) * 4;
        grp  = cla4(a_q[k][base +: 4], b_q[k][base +: 4], carry);
        s_d[k+1][base +: 4] = grp[3:0];
        c_msb = grp[4];
        carry = grp[5];
      end
      c_d[k+1] = carry;
    end
    ovf_d  = c_msb ^ carry;
    zero_d = (s_d[LAT] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k <= LAT; k++) s_q[k] <= '0;
    end else if (adv) begin
      v_q    <= v_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k <= LAT; k++) s_q[k] <= s_d[k];
    end
  end

  // Operand slices carry no control meaning, so they skip reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < LAT; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign in_ready  = adv | !rst_n;
  assign out_valid = v_q[LAT];
  assign s         = s_q[LAT];
  assign co        = c_q[LAT];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
